// File: rtl/audio_pkg.sv
// Shared audio-path types: sample word, I2S word length, receiver states and channel codes.
package audio_pkg;

  typedef logic [31:0] sample_t;

  localparam int I2S_WORD_BITS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } rx_state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with a history flop for edge detection.
// STAGES must be 2 or more.
module pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall,
  output logic any_edge
);

  logic [STAGES-1:0] chain;
  logic              hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      hist  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
      hist  <= chain[STAGES-1];
    end
  end

  assign level    = chain[STAGES-1];
  assign rise     = level & ~hist;
  assign fall     = ~level & hist;
  assign any_edge = level ^ hist;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples BCLK/LRCLK/ADCDAT on CLK and deserialises each half-frame.
// Define I2S_RX_FRAME_ERR_EN to build the short-frame flag and counter.
module i2s_rx
  import audio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_BITS   = I2S_WORD_BITS
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 ENABLE,
  input  logic                 BCLK,
  input  logic                 LRCLK,
  input  logic                 ADCDAT,
  output logic [WORD_BITS-1:0] DOUTL,
  output logic [WORD_BITS-1:0] DOUTR,
  output logic                 VALID_L,
  output logic                 VALID_R,
  output logic                 FRAME_ERR,
  output logic [7:0]           ERR_CNT
);

  // state | meaning
  // IDLE  | capture disabled, counter held at 0
  // SEEK  | enabled, waiting for an LRCLK edge so no partial half-frame is taken
  // SHIFT | shifting bits of the current half-frame
  // DONE  | word complete, extra BCLKs ignored until the next LRCLK edge
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SEEK  = SEEK;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_DONE  = DONE;

  localparam int CNT_W = 6;

  logic bclk_rise, lr_edge, lr_level, dat_level;
  logic bclk_level, bclk_fall, bclk_any, lr_rise, lr_fall, dat_rise, dat_fall, dat_any;

  pin_sync #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk(CLK), .rst_n(RESET_N), .pin(BCLK),
    .level(bclk_level), .rise(bclk_rise), .fall(bclk_fall), .any_edge(bclk_any)
  );

  pin_sync #(.STAGES(SYNC_STAGES)) u_sync_lrclk (
    .clk(CLK), .rst_n(RESET_N), .pin(LRCLK),
    .level(lr_level), .rise(lr_rise), .fall(lr_fall), .any_edge(lr_edge)
  );

  pin_sync #(.STAGES(SYNC_STAGES)) u_sync_adcdat (
    .clk(CLK), .rst_n(RESET_N), .pin(ADCDAT),
    .level(dat_level), .rise(dat_rise), .fall(dat_fall), .any_edge(dat_any)
  );

  logic [1:0]           state, state_nx;
  logic [CNT_W-1:0]     bit_cnt;
  logic [WORD_BITS-1:0] shreg;
  logic                 channel;
  logic                 word_done_q;
  logic                 bit_last, capture_start, shift_en, word_done, short_frame;

  assign bit_last = (bit_cnt == CNT_W'(WORD_BITS - 1));

  // An LRCLK edge always wins over a coincident BCLK rise.
  assign capture_start = ENABLE && lr_edge && (state != S_IDLE);
  // The final shift still lands when ENABLE drops in the same cycle.
  assign shift_en    = (state == S_SHIFT) && bclk_rise && !lr_edge && (ENABLE || bit_last);
  assign word_done   = shift_en && bit_last;
  assign short_frame = ENABLE && lr_edge && (state == S_SHIFT);

  always_comb begin
    state_nx = state;
    if (!ENABLE) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nx = S_SEEK;
        S_SEEK:  if (lr_edge) state_nx = S_SHIFT;
        S_SHIFT: if (!lr_edge && bclk_rise && bit_last) state_nx = S_DONE;
        S_DONE:  if (lr_edge) state_nx = S_SHIFT;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= S_SEEK;
      bit_cnt     <= '0;
      shreg       <= '0;
      channel     <= CH_LEFT;
      word_done_q <= 1'b0;
      DOUTL       <= '0;
      DOUTR       <= '0;
      VALID_L     <= 1'b0;
      VALID_R     <= 1'b0;
    end else begin
      state       <= state_nx;
      word_done_q <= word_done;
      VALID_L     <= 1'b0;
      VALID_R     <= 1'b0;

      if (word_done_q) begin
        if (channel == CH_LEFT) begin
          DOUTL   <= shreg;
          VALID_L <= 1'b1;
        end else begin
          DOUTR   <= shreg;
          VALID_R <= 1'b1;
        end
      end

      if (capture_start) begin
        channel <= lr_level;
        shreg   <= {{(WORD_BITS-1){1'b0}}, dat_level & bclk_rise};
        bit_cnt <= CNT_W'(bclk_rise);
      end else if (shift_en) begin
        shreg   <= {shreg[WORD_BITS-2:0], dat_level};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else if (!ENABLE || state == S_IDLE) begin
        bit_cnt <= '0;
      end
    end
  end

`ifdef I2S_RX_FRAME_ERR_EN
  logic       err_flag;
  logic [7:0] err_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else if (short_frame) begin
      err_flag <= 1'b1;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign FRAME_ERR = err_flag;
  assign ERR_CNT   = err_cnt;

  logic unused_sink;
  assign unused_sink = &{1'b0, bclk_level, bclk_fall, bclk_any, lr_rise, lr_fall,
                         dat_rise, dat_fall, dat_any};
`else
  assign FRAME_ERR = 1'b0;
  assign ERR_CNT   = '0;

  logic unused_sink;
  assign unused_sink = &{1'b0, bclk_level, bclk_fall, bclk_any, lr_rise, lr_fall,
                         dat_rise, dat_fall, dat_any, short_frame};
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Randomised scoreboard bench for i2s_rx: reference model built from half-frame rules.
module tb_i2s_rx;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;
  localparam int HALF = 8;  // BCLK = CLK/16

  logic        CLK = 1'b0;
  logic        RESET_N, ENABLE, BCLK, LRCLK, ADCDAT;
  logic [31:0] DOUTL, DOUTR;
  logic        VALID_L, VALID_R, FRAME_ERR;
  logic [7:0]  ERR_CNT;

  i2s_rx #(.SYNC_STAGES(SYNC), .WORD_BITS(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .BCLK(BCLK), .LRCLK(LRCLK),
    .ADCDAT(ADCDAT), .DOUTL(DOUTL), .DOUTR(DOUTR), .VALID_L(VALID_L),
    .VALID_R(VALID_R), .FRAME_ERR(FRAME_ERR), .ERR_CNT(ERR_CNT)
  );

  always #10 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic        ch;
    logic [31:0] word;
    int unsigned t;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  logic        en_model   = 1'b0;
  logic        capturing  = 1'b0;
  logic        cur_ch     = 1'b0;
  int          cur_bits   = 0;
  logic [31:0] mword      = '0;
  logic [31:0] last_l     = '0;
  logic [31:0] last_r     = '0;
  int          exp_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_doutl"}, DOUTL, last_l);
    check({tag, "_doutr"}, DOUTR, last_r);
`ifdef I2S_RX_FRAME_ERR_EN
    check({tag, "_frame_err"}, 32'(FRAME_ERR), 32'(exp_err != 0));
    check({tag, "_err_cnt"}, 32'(ERR_CNT), 32'(exp_err));
`else
    check({tag, "_frame_err"}, 32'(FRAME_ERR), 32'd0);
    check({tag, "_err_cnt"}, 32'(ERR_CNT), 32'd0);
`endif
  endtask

  // A new half-frame begins: close the previous one, arm capture if enabled.
  task automatic model_edge(input logic lr);
    if (capturing && cur_bits < 32 && exp_err < 255) exp_err++;
    capturing = en_model;
    cur_bits  = 0;
    mword     = '0;
    cur_ch    = lr;
  endtask

  task automatic model_rise(input logic b);
    exp_t e;
    if (!capturing) return;
    cur_bits++;
    if (cur_bits <= 32) mword = {mword[30:0], b};
    if (cur_bits == 32) begin
      e.ch = cur_ch; e.word = mword; e.t = cyc;
      sb.push_back(e);
      if (cur_ch) last_r = mword; else last_l = mword;
    end
  endtask

  task automatic bit_cycle(input logic b);
    BCLK = 1'b0; ADCDAT = b;
    tick(HALF);
    BCLK = 1'b1;
    model_rise(b);
    tick(HALF);
  endtask

  // ev_kind: 0 none, 1 ENABLE rises, 2 ENABLE drops then rises 6 bits later, 3 reset pulse
  task automatic send_half(input logic lr, input logic [31:0] w, input int nbits,
                           input int ev_bit, input int ev_kind);
    logic b;
    if (lr !== LRCLK) model_edge(lr);
    LRCLK = lr;
    for (int i = 0; i < nbits; i++) begin
      if (i == ev_bit) begin
        if (ev_kind == 1) begin
          ENABLE = 1'b1; en_model = 1'b1;
        end else if (ev_kind == 2) begin
          ENABLE = 1'b0; en_model = 1'b0; capturing = 1'b0;
        end else if (ev_kind == 3) begin
          RESET_N = 1'b0;
          #1;
          check("rst_doutl", DOUTL, 32'd0);
          check("rst_doutr", DOUTR, 32'd0);
          check("rst_valid", 32'({VALID_L, VALID_R}), 32'd0);
          check("rst_err", 32'({FRAME_ERR, ERR_CNT}), 32'd0);
          capturing = 1'b0; last_l = '0; last_r = '0; exp_err = 0;
          tick(2);
          RESET_N = 1'b1;
        end
      end
      if (ev_kind == 2 && i == ev_bit + 6) begin
        ENABLE = 1'b1; en_model = 1'b1;
      end
      b = (i < 32) ? w[31-i] : 1'($urandom_range(0, 1));
      bit_cycle(b);
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (VALID_L === 1'b1 || VALID_R === 1'b1) begin
        check("valid_exclusive", 32'(VALID_L & VALID_R), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'({VALID_L, VALID_R}), 32'd0);
        end else begin
          e = sb.pop_front();
          check("valid_channel", 32'(VALID_R), 32'(e.ch));
          check("word", VALID_R ? DOUTR : DOUTL, e.word);
          check("latency", cyc - e.t, 32'(LAT));
        end
      end
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $finish;
  end

  initial begin
    logic lr;
    int   nb;
    RESET_N = 1'b0; ENABLE = 1'b0; BCLK = 1'b0; LRCLK = 1'b0; ADCDAT = 1'b0;
    tick(3);
    RESET_N = 1'b1;
    tick(2);
    check_outputs("reset");
    check("reset_valid", 32'({VALID_L, VALID_R}), 32'd0);

    // enable arrives mid right half-frame: that partial frame is skipped
    send_half(1'b0, $urandom, 32, -1, 0);
    send_half(1'b1, $urandom, 32, 10, 1);
    send_half(1'b0, 32'h5A5A5A5A, 32, -1, 0);
    check_outputs("first_left");

    // continuous stereo, fixed then random words
    for (int k = 0; k < 3; k++) begin
      send_half(1'b1, 32'h7FFFFF00, 32, -1, 0);
      send_half(1'b0, 32'h80000001, 32, -1, 0);
    end
    for (int k = 0; k < 4; k++) begin
      send_half(1'b1, $urandom, 32, -1, 0);
      send_half(1'b0, $urandom, 32, -1, 0);
    end
    check_outputs("stereo");

    // short left half-frame of 20 bits
    send_half(1'b1, $urandom, 32, -1, 0);
    send_half(1'b0, $urandom, 20, -1, 0);
    send_half(1'b1, $urandom, 32, -1, 0);
    check_outputs("short");
    send_half(1'b0, $urandom, 32, -1, 0);
    check_outputs("after_short");

    // 40 BCLKs in one half-frame
    send_half(1'b1, $urandom, 32, -1, 0);
    send_half(1'b0, 32'hCAFEF00D, 40, -1, 0);
    send_half(1'b1, $urandom, 32, -1, 0);
    check_outputs("long");

    // reset mid-word at bit 17
    send_half(1'b0, $urandom, 32, 17, 3);
    check_outputs("post_reset");
    send_half(1'b1, $urandom, 32, -1, 0);
    send_half(1'b0, $urandom, 32, -1, 0);
    check_outputs("resume");

    // ENABLE dropped mid-word, raised ~100 CLK later
    send_half(1'b1, $urandom, 32, 8, 2);
    send_half(1'b0, $urandom, 32, -1, 0);
    send_half(1'b1, $urandom, 32, -1, 0);
    check_outputs("enable_drop");

    // random lengths and words
    lr = 1'b0;
    for (int k = 0; k < 12; k++) begin
      nb = $urandom_range(24, 36);
      send_half(lr, $urandom, nb, -1, 0);
      lr = ~lr;
    end
    send_half(lr, $urandom, 32, -1, 0);
    send_half(~lr, $urandom, 32, -1, 0);
    tick(20);
    check_outputs("random");
    check("pending_words", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Serial-to-parallel I2S receiver for the codec ADC path; sits directly upstream of the overdrive/effects stage and drives its 32-bit DINL/DINR inputs.
- Oversamples the codec's BCLK, LRCLK and ADCDAT pins with the single system clock, then deserialises each half-frame into a 32-bit word.
- Presents stable left/right words with one-cycle valid strobes.

Parameters:
- SYNC_STAGES, 2, flip-flops per pin synchroniser (minimum 2).
- WORD_BITS, 32, bits captured per channel half-frame.

Ports:
- CLK  in  1  system clock (50 MHz); must be at least 4x BCLK.
- RESET_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  capture enable; low = idle, outputs hold.
- BCLK  in  1  codec bit clock, asynchronous to CLK.
- LRCLK  in  1  codec word clock, asynchronous; low = left, high = right.
- ADCDAT  in  1  codec serial data, MSB first.
- DOUTL  out  32  last complete left word.
- DOUTR  out  32  last complete right word.
- VALID_L  out  1  one-CLK pulse when DOUTL updates.
- VALID_R  out  1  one-CLK pulse when DOUTR updates.
- FRAME_ERR  out  1  sticky short-frame flag (optional feature).
- ERR_CNT  out  8  saturating short-frame count (optional feature).

Behaviour:
- Reset: all outputs 0, shift register 0, bit counter 0, state SEEK, synchronisers 0. RESET_N asserted at any time, including mid-word, aborts the word; no VALID is issued for it.
- Synchronisation and edge detection:
  - BCLK, LRCLK and ADCDAT each pass through SYNC_STAGES flops plus one history flop.
  - bclk_rise = sync high and history low. lr_edge = sync differs from history.
  - ADCDAT is sampled from its synchronised copy in the cycle bclk_rise is seen. The equal path depth keeps data aligned with the clock.
- Bit ordering:
  - The word is the WORD_BITS samples taken on the first WORD_BITS BCLK rising edges after an LRCLK edge, shifted in MSB-first (shift left, new bit into bit 0).
  - The I2S one-bit delay slot lands in bit 31. The 24-bit audio sample occupies [30:7].
- State machine:
  - IDLE: entered whenever ENABLE=0, from any state. Counter is cleared and no VALID is issued.
  - SEEK: entered when ENABLE rises; waits for lr_edge. This prevents capturing a partial half-frame.
  - SHIFT:
    - On lr_edge, clear the counter and latch the channel (synchronised LRCLK level after the edge).
    - Each bclk_rise shifts one bit and increments the counter.
    - When the counter reaches WORD_BITS, go to DONE.
  - DONE: ignore further BCLK edges. lr_edge returns to SHIFT for the next channel.
- Output:
  - In the CLK cycle after the WORD_BITS-th shift, the word is copied to DOUTL (channel 0) or DOUTR (channel 1), and VALID_L or VALID_R is high for exactly that one cycle.
  - Latency from the pin-level BCLK rise of the last bit to VALID is SYNC_STAGES+2 CLK.
- Short frame: lr_edge in SHIFT with counter < WORD_BITS discards the partial word. No VALID is issued and outputs keep their old values. Capture restarts for the new channel.
- Simultaneous events:
  - lr_edge and bclk_rise in the same cycle: the edge wins. The counter is set to 1 and the sampled bit becomes the first bit of the new word.
  - ENABLE falling in the same cycle as the completion shift: the word is still delivered with VALID, then the block goes to IDLE.
- Counter width: 6 bits, never exceeds WORD_BITS.

Optional Feature:
- Macro: I2S_RX_FRAME_ERR_EN.
- Defined:
  - Each short frame sets FRAME_ERR, which stays set until reset.
  - Each short frame increments ERR_CNT, which saturates at 255.
  - The short frame that follows ENABLE rising is not counted, because SEEK skips it.
- Undefined: FRAME_ERR and ERR_CNT are tied to 0 and no counter logic is synthesised. The ports remain present in both builds.

Decomposition:
- Shared package audio_pkg:
  - typedef sample_t = logic [31:0].
  - localparam I2S_WORD_BITS = 32.
  - enum rx_state_t {IDLE, SEEK, SHIFT, DONE}.
  - CH_LEFT=0, CH_RIGHT=1.
- One sub-module, pin_sync: a SYNC_STAGES-deep synchroniser with an edge-detect history flop and rise/fall/any-edge outputs. It is instantiated three times.

Test Plan:
- Stimulus: reset, ENABLE=1, BCLK=CLK/16, one left half-frame carrying 0x5A5A5A5A. Required: the first partial frame is skipped; the next left frame gives DOUTL=0x5A5A5A5A with a 1-cycle VALID_L exactly SYNC_STAGES+2 CLK after the 32nd BCLK rise; DOUTR stays 0.
- Stimulus: continuous stereo, L=0x80000001, R=0x7FFFFF00. Required: VALID_L and VALID_R alternate, one per half-frame; values match exactly; never both high in one cycle.
- Stimulus: half-frame of only 20 BCLKs before LRCLK toggles. Required: no VALID, DOUTL unchanged; with I2S_RX_FRAME_ERR_EN, FRAME_ERR=1 and ERR_CNT=1; next full frame captured correctly.
- Stimulus: 40 BCLKs in one half-frame, first 32 bits 0xCAFEF00D. Required: DOUTL=0xCAFEF00D; extra 8 bits ignored; no error.
- Stimulus: RESET_N pulsed low mid-word (bit 17). Required: all outputs 0 immediately; no VALID; capture resumes only after the next LRCLK edge.
- Stimulus: ENABLE dropped mid-word, raised again 100 CLK later. Required: partial word discarded; SEEK skips the in-progress half-frame; the following frame is captured correctly; ERR_CNT is not incremented.
